rf_dump: RTL
============

RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 Parameter NREGS, default 4, number of register-file entries to stream (power of two, >= 2).
REQ-002 Parameter AW, default 2, register index width, equal to log2(NREGS).
REQ-003 Parameter HDR, default 8'hA5, header byte that opens every dump frame.
REQ-004 clock  input  1  single clock; all state changes on the rising edge.
REQ-005 clear_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  dump request, sampled only in IDLE.
REQ-007 rs  output  AW  read index to the register file read port.
REQ-008 rval  input  8  register-file read data, combinational from rs in the same cycle.
REQ-009 tx_data  output  8  stream byte, registered.
REQ-010 tx_valid  output  1  stream byte valid.
REQ-011 tx_ready  input  1  downstream accept; a transfer occurs when tx_valid and tx_ready are both 1 on a rising edge.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the checksum byte transfers.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, HDR, DATA and SUM.
REQ-015 The frame SHALL be HDR, then entries 0..NREGS-1 in ascending index order, then one checksum byte; total length is NREGS+2 bytes.
REQ-016 In IDLE, start=1 at edge t SHALL enter HDR with tx_data=HDR and tx_valid=1, both visible after edge t (latency 1).
REQ-017 start SHALL be ignored while busy=1; there is no queuing of requests.
REQ-018 While tx_valid=1 and tx_ready=0, tx_data, rs and state SHALL hold stable.
REQ-019 An internal index idx (AW+1 bits) SHALL drive rs=idx[AW-1:0]; idx=0 on entry to HDR.
REQ-020 On each transfer in HDR or DATA with idx<NREGS: tx_data<=rval, chk<=chk^rval, idx<=idx+1, state<=DATA.
REQ-021 On a DATA transfer with idx==NREGS: tx_data<=chk, state<=SUM.
REQ-022 chk SHALL be the 8-bit XOR of all data bytes; it is cleared to 0 on entry to HDR; the header is excluded from chk.
REQ-023 On a SUM transfer: tx_valid<=0, done<=1 for one cycle, state<=IDLE.
REQ-024 A start asserted in the cycle where done=1 SHALL be accepted (back-to-back frames, with one idle cycle minimum between frames).
REQ-025 With tx_ready held at 1, the timing SHALL be: start at edge t; header visible t+1; data t+2..t+NREGS+1; checksum t+NREGS+2; done at t+NREGS+3.
REQ-026 Each entry SHALL be captured at its own transfer edge; register-file writes during a dump are reflected only in entries not yet captured, and no atomic snapshot is provided.
REQ-027 tx_valid SHALL never deassert without a transfer.

Reset
REQ-028 clear_n=0 SHALL immediately force: state=IDLE, tx_valid=0, tx_data=0, idx=0, chk=0, done=0, busy=0; rs then reads 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no done pulse; the first post-reset start emits a complete new frame.
REQ-030 Reset deassertion SHALL take effect at the next rising edge; start sampled on that edge is honoured.

Structure
REQ-031 Shared package rf_pkg SHALL hold the state encoding (IDLE, HDR, DATA, SUM), the HDR default value and the register data width 8.
REQ-032 The block SHALL be flat, with no sub-modules; the bench SHALL pair it with the team's rf register file (rs to rs1, rval1 to rval).

Verification
REQ-033 Load regs 0x11, 0x22, 0x33, 0x44, hold tx_ready=1, pulse start -> stream A5, 11, 22, 33, 44, 44; done exactly at t+7.
REQ-034 Same load, toggle tx_ready on a 1-0 pattern -> identical byte sequence; tx_data stable during every stall.
REQ-035 Pulse start again during DATA -> ignored; exactly one frame of 6 bytes.
REQ-036 Write reg3=0x99 while byte 0x22 is being held -> frame A5, 11, 22, 33, 99, checksum 0x99.
REQ-037 Assert clear_n=0 during SUM -> tx_valid=0 immediately and no done pulse; next start yields a full frame.
REQ-038 All regs 0x00 with back-to-back start on the done cycle -> two frames A5, 00, 00, 00, 00, 00, with one idle cycle between them.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared types and constants for the register-file dump engine.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int c_DW = 8;
    localparam logic [c_DW-1:0] c_HDR_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_SUM  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_dump.sv
`default_nettype none
// ============================================================================
// Module      : rf_dump
// Description : Streams a header, every register-file entry and an XOR
//               checksum as a valid/ready byte frame.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_dump
    import rf_pkg::*;
#(
    parameter int              NREGS = 4,
    parameter int              AW    = 2,
    parameter logic [c_DW-1:0] HDR   = c_HDR_DEFAULT
) (
    input  logic            clock,
    input  logic            clear_n,
    input  logic            start,
    output logic [AW-1:0]   rs,
    input  logic [c_DW-1:0] rval,
    output logic [c_DW-1:0] tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [AW:0] c_NREGS = (AW+1)'(NREGS);

    state_t          r_state;
    logic [AW:0]     r_idx;
    logic [c_DW-1:0] r_chk;
    logic [c_DW-1:0] r_data;
    logic            r_valid;
    logic            r_done;
    logic            w_xfer;

    assign w_xfer = r_valid && tx_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_chk   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_HDR;
                        r_data  <= HDR;
                        r_valid <= 1'b1;
                        r_idx   <= '0;
                        r_chk   <= '0;
                    end
                end
                S_HDR, S_DATA: begin
                    // Each entry is sampled on the edge that retires the previous byte.
                    if (w_xfer) begin
                        if (r_idx < c_NREGS) begin
                            r_data  <= rval;
                            r_chk   <= r_chk ^ rval;
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_DATA;
                        end else begin
                            r_data  <= r_chk;
                            r_state <= S_SUM;
                        end
                    end
                end
                S_SUM: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rs       = r_idx[AW-1:0];
    assign tx_data  = r_data;
    assign tx_valid = r_valid;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

endmodule
`default_nettype wire
